spi_slave_fsm: RTL and testbench

Serial-to-parallel front end of the SPI slave. It receives framed MOSI bits under SS_n and presents 10-bit command/data words (`rx_data`, `rx_valid`) to the single-port RAM stage. It also returns the RAM's 8-bit read data (`tx_data`, `tx_valid`) on MISO, MSB first. The block runs directly on the SPI bit clock: one `clk` edge per serial bit.

---
 rtl/spi_slave_fsm.sv | 158 +++++++++++++++
 tb/tb_spi_slave_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI slave serial front end, clocked by the SPI bit clock.
// Assembles 10-bit command/data words from MOSI and shifts RAM read bytes out on MISO.
// Optional macro SPI_RD_ORDER_CHECK_EN: discard read-path words whose command bits
// do not match the expected read phase (2'b10 for the address, 2'b11 for the data).
// Ports:
//   clk      in   SPI bit clock, rising edge
//   rst_n    in   synchronous active-low reset
//   SS_n     in   slave select, active-low
//   MOSI     in   serial data from the master, MSB first
//   tx_data  in   [7:0] read byte from the RAM stage
//   tx_valid in   tx_data valid
//   rx_data  out  [9:0] assembled word, [9:8] command, [7:0] address/data
//   rx_valid out  one-cycle strobe qualifying rx_data
//   MISO     out  serial read data to the master, MSB first
module spi_slave_fsm #(
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    output logic       MISO
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t     state_q;
    logic [9:0] rx_sh_q;
    logic [3:0] bit_cnt_q;
    logic       done_q;
    logic       rd_addr_seen_q;
    logic [7:0] tx_sh_q;
    logic [2:0] tx_cnt_q;
    logic       tx_busy_q;
    logic       tx_loaded_q;
    logic [9:0] rx_data_q;
    logic       rx_valid_q;
    logic       miso_q;

    logic [9:0] word_d;
    logic       last_bit_d;
    logic       word_ok_d;

    always_comb begin
        word_d     = {rx_sh_q[8:0], MOSI};
        last_bit_d = (bit_cnt_q == 4'd9);
        word_ok_d  = 1'b1;
`ifdef SPI_RD_ORDER_CHECK_EN
        if (state_q == READ_ADD)
            word_ok_d = (word_d[9:8] == 2'b10);
        else if (state_q == READ_DATA)
            word_ok_d = (word_d[9:8] == 2'b11);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rx_sh_q        <= '0;
            bit_cnt_q      <= '0;
            done_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_sh_q        <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_loaded_q    <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= MISO_IDLE;
        end else begin
            rx_valid_q <= 1'b0;
            // Deselect aborts the frame; the pre-edge SS_n decides.
            if (state_q != IDLE && SS_n) begin
                state_q     <= IDLE;
                rx_sh_q     <= '0;
                bit_cnt_q   <= '0;
                done_q      <= 1'b0;
                tx_sh_q     <= '0;
                tx_cnt_q    <= '0;
                tx_busy_q   <= 1'b0;
                tx_loaded_q <= 1'b0;
                miso_q      <= MISO_IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!SS_n)
                            state_q <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        bit_cnt_q   <= '0;
                        rx_sh_q     <= '0;
                        done_q      <= 1'b0;
                        tx_loaded_q <= 1'b0;
                        if (!MOSI)
                            state_q <= WRITE;
                        else if (rd_addr_seen_q)
                            state_q <= READ_DATA;
                        else
                            state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!done_q) begin
                            rx_sh_q   <= word_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (last_bit_d) begin
                                done_q <= 1'b1;
                                if (word_ok_d) begin
                                    rx_data_q  <= word_d;
                                    rx_valid_q <= 1'b1;
                                    if (state_q == READ_ADD)
                                        rd_addr_seen_q <= 1'b1;
                                    if (state_q == READ_DATA)
                                        rd_addr_seen_q <= 1'b0;
                                end else begin
                                    // Rejected read word: block the byte return.
                                    tx_loaded_q <= 1'b1;
                                end
                            end
                        end else if (state_q == READ_DATA) begin
                            if (tx_busy_q) begin
                                if (tx_cnt_q != 3'd0) begin
                                    miso_q   <= tx_sh_q[7];
                                    tx_sh_q  <= {tx_sh_q[6:0], 1'b0};
                                    tx_cnt_q <= tx_cnt_q - 3'd1;
                                end else begin
                                    miso_q    <= MISO_IDLE;
                                    tx_busy_q <= 1'b0;
                                end
                            end else if (!tx_loaded_q && tx_valid) begin
                                miso_q      <= tx_data[7];
                                tx_sh_q     <= {tx_data[6:0], 1'b0};
                                tx_cnt_q    <= 3'd7;
                                tx_busy_q   <= 1'b1;
                                tx_loaded_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign MISO     = miso_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: directed self-checking bench for spi_slave_fsm.
// Inputs driven and outputs sampled on the falling edge.
module tb_spi_slave_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       MISO;

    int total = 0;
    int bad   = 0;

    spi_slave_fsm #(.MISO_IDLE(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives E0..E11 of a frame; returns observations up to E11.
    task automatic run_word(
        input  logic       sel,
        input  logic [9:0] w,
        output int         early,
        output logic [2:0] st_sel,
        output logic       vld11,
        output logic [9:0] d11,
        output int         miso_hi
    );
        early   = 0;
        miso_hi = 0;
        cyc(1'b0, 1'b0);
        if (rx_valid) early++;
        cyc(1'b0, sel);
        st_sel = dut.state_q;
        if (rx_valid) early++;
        for (int i = 9; i >= 0; i--) begin
            cyc(1'b0, w[i]);
            if (i != 0 && rx_valid) early++;
            if (MISO) miso_hi++;
        end
        vld11 = rx_valid;
        d11   = rx_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL reset_rx_data got=%h want=000", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", MISO); end
        total++; if (dut.state_q !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dut.state_q); end
        total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL reset_seen got=%b want=0", dut.rd_addr_seen_q); end
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);
    endtask

    task automatic test_write_addr;
        int e, mh;
        logic [2:0] st;
        logic v;
        logic [9:0] d;
        run_word(1'b0, 10'h03C, e, st, v, d, mh);
        total++; if (st !== 3'd2) begin bad++; $display("FAIL wa_state got=%0d want=2", st); end
        total++; if (e !== 0) begin bad++; $display("FAIL wa_early_valid got=%0d want=0", e); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL wa_rx_valid got=%b want=1", v); end
        total++; if (d !== 10'h03C) begin bad++; $display("FAIL wa_rx_data got=%h want=03c", d); end
        cyc(1'b0, 1'b1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wa_strobe_len got=%b want=0", rx_valid); end
        cyc(1'b0, 1'b1);
        total++; if (mh !== 0 || MISO !== 1'b0) begin bad++; $display("FAIL wa_miso got=%0d/%b want=0/0", mh, MISO); end
        cyc(1'b1, 1'b0);
        total++; if (dut.state_q !== 3'd0) begin bad++; $display("FAIL wa_end_state got=%0d want=0", dut.state_q); end
    endtask

    task automatic test_write_data;
        int e, mh;
        logic [2:0] st;
        logic v;
        logic [9:0] d;
        run_word(1'b0, 10'h1A5, e, st, v, d, mh);
        total++; if (v !== 1'b1 || e !== 0) begin bad++; $display("FAIL wd_rx_valid got=%b/%0d want=1/0", v, e); end
        total++; if (d !== 10'h1A5) begin bad++; $display("FAIL wd_rx_data got=%h want=1a5", d); end
        cyc(1'b0, 1'b0);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wd_strobe_len got=%b want=0", rx_valid); end
        cyc(1'b1, 1'b0);
    endtask

    task automatic test_read_seq;
        int e, mh, hi;
        logic [2:0] st;
        logic v;
        logic [9:0] d;
        logic [7:0] exp;
        run_word(1'b1, 10'h23C, e, st, v, d, mh);
        total++; if (st !== 3'd3) begin bad++; $display("FAIL ra_state got=%0d want=3", st); end
        total++; if (v !== 1'b1 || d !== 10'h23C) begin bad++; $display("FAIL ra_word got=%b/%h want=1/23c", v, d); end
        total++; if (dut.rd_addr_seen_q !== 1'b1) begin bad++; $display("FAIL ra_seen got=%b want=1", dut.rd_addr_seen_q); end
        cyc(1'b1, 1'b0);
        run_word(1'b1, 10'h300, e, st, v, d, mh);
        total++; if (st !== 3'd4) begin bad++; $display("FAIL rd_state got=%0d want=4", st); end
        total++; if (v !== 1'b1 || d !== 10'h300) begin bad++; $display("FAIL rd_word got=%b/%h want=1/300", v, d); end
        total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL rd_seen got=%b want=0", dut.rd_addr_seen_q); end
        cyc(1'b0, 1'b0);
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_miso_pre got=%b want=0", MISO); end
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        exp      = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b0, 1'b0);
            total++; if (MISO !== exp[i]) begin bad++; $display("FAIL rd_miso_bit%0d got=%b want=%b", i, MISO, exp[i]); end
        end
        tx_data = 8'hFF;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            if (MISO) hi++;
        end
        total++; if (hi !== 0) begin bad++; $display("FAIL rd_single_load got=%0d want=0", hi); end
        cyc(1'b1, 1'b0);
        tx_valid = 1'b0;
        total++; if (dut.state_q !== 3'd0) begin bad++; $display("FAIL rd_end_state got=%0d want=0", dut.state_q); end
    endtask

    task automatic test_abort;
        int e, mh, vc, hi;
        logic [2:0] st;
        logic v;
        logic [9:0] d;
        run_word(1'b1, 10'h255, e, st, v, d, mh);
        cyc(1'b1, 1'b0);
        total++; if (dut.rd_addr_seen_q !== 1'b1) begin bad++; $display("FAIL ab_setup_seen got=%b want=1", dut.rd_addr_seen_q); end
        vc = 0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1);
            if (rx_valid) vc++;
        end
        cyc(1'b1, 1'b1);
        if (rx_valid) vc++;
        total++; if (dut.state_q !== 3'd0) begin bad++; $display("FAIL ab_state got=%0d want=0", dut.state_q); end
        cyc(1'b1, 1'b0);
        if (rx_valid) vc++;
        total++; if (vc !== 0) begin bad++; $display("FAIL ab_no_valid got=%0d want=0", vc); end
        total++; if (dut.rd_addr_seen_q !== 1'b1) begin bad++; $display("FAIL ab_seen got=%b want=1", dut.rd_addr_seen_q); end
        run_word(1'b1, 10'h300, e, st, v, d, mh);
        total++; if (st !== 3'd4 || v !== 1'b1) begin bad++; $display("FAIL ab_rd_after got=%0d/%b want=4/1", st, v); end
        cyc(1'b1, 1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            if (MISO) hi++;
        end
        tx_valid = 1'b0;
        total++; if (hi !== 0) begin bad++; $display("FAIL ab_late_tx got=%0d want=0", hi); end
    endtask

    task automatic test_order;
        int e, mh;
        logic [2:0] st;
        logic v;
        logic [9:0] d;
        run_word(1'b1, 10'h300, e, st, v, d, mh);
        total++; if (st !== 3'd3) begin bad++; $display("FAIL oc_state got=%0d want=3", st); end
`ifdef SPI_RD_ORDER_CHECK_EN
        total++; if (v !== 1'b0 || e !== 0) begin bad++; $display("FAIL oc_discard got=%b/%0d want=0/0", v, e); end
        total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL oc_seen got=%b want=0", dut.rd_addr_seen_q); end
        cyc(1'b1, 1'b0);
`else
        total++; if (v !== 1'b1 || d !== 10'h300) begin bad++; $display("FAIL oc_forward got=%b/%h want=1/300", v, d); end
        total++; if (dut.rd_addr_seen_q !== 1'b1) begin bad++; $display("FAIL oc_seen got=%b want=1", dut.rd_addr_seen_q); end
        cyc(1'b1, 1'b0);
        run_word(1'b1, 10'h200, e, st, v, d, mh);
        total++; if (st !== 3'd4 || v !== 1'b1 || d !== 10'h200) begin bad++; $display("FAIL oc_toggle got=%0d/%b/%h want=4/1/200", st, v, d); end
        cyc(1'b1, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_shift;
        int e, mh;
        logic [2:0] st;
        logic v;
        logic [9:0] d;
        run_word(1'b1, 10'h2AA, e, st, v, d, mh);
        cyc(1'b1, 1'b0);
        run_word(1'b1, 10'h3AA, e, st, v, d, mh);
        cyc(1'b0, 1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        cyc(1'b0, 1'b0);
        total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rm_shift_start got=%b want=1", MISO); end
        cyc(1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rm_miso got=%b want=0", MISO); end
        total++; if (rx_valid !== 1'b0 || rx_data !== 10'h000) begin bad++; $display("FAIL rm_rx got=%b/%h want=0/000", rx_valid, rx_data); end
        total++; if (dut.state_q !== 3'd0) begin bad++; $display("FAIL rm_state got=%0d want=0", dut.state_q); end
        total++; if (dut.rd_addr_seen_q !== 1'b0) begin bad++; $display("FAIL rm_seen got=%b want=0", dut.rd_addr_seen_q); end
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        @(negedge clk);
        test_reset;
        test_write_addr;
        test_write_data;
        test_read_seq;
        test_abort;
        test_order;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
